matmul_sequencer: RTL and testbench

Sequences the shared `SequentialMultiplier` through a full signed matrix product OUT = ReLU(M × W), with M of size ROWS×COLUMNS and W of size COLUMNS×W_COL. For each output element it fetches operand pairs from two synchronous-read operand memories, issues one multiply per k, and accumulates the signed products. It then applies ReLU and emits the result on a valid/ready write port. It sits between the MFCC/weight buffers and the output buffer, and is the only master of the multiplier's Start input.

---
 rtl/matmul_sequencer_if.sv | 57 +++++
 rtl/matmul_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_sequencer_if.sv
// Bus bundle between matmul_sequencer and its surroundings.
// Carries the M/W operand-memory read ports, the shared multiplier port
// and the result write port.
//   master : the sequencer (drives addresses, operands, start, result)
//   slave  : memories, multiplier and output buffer
interface matmul_sequencer_if #(
   parameter int unsigned N       = 8,
   parameter int unsigned ROWS    = 402,
   parameter int unsigned COLUMNS = 26,
   parameter int unsigned W_COL   = 128,
   parameter int unsigned ACC_W   = 2*N+5
);
   localparam int unsigned RW = (ROWS > 1)    ? $clog2(ROWS)    : 1;
   localparam int unsigned KW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
   localparam int unsigned JW = (W_COL > 1)   ? $clog2(W_COL)   : 1;
   localparam int unsigned PW = 2*N;

   // operand memories (synchronous read, data one cycle after address)
   logic        [RW-1:0]    m_addr_row;
   logic        [KW-1:0]    m_addr_col;
   logic        [KW-1:0]    w_addr_row;
   logic        [JW-1:0]    w_addr_col;
   logic signed [N-1:0]     m_data;
   logic signed [N-1:0]     w_data;

   // shared sequential multiplier
   logic signed [N-1:0]     multiplicand;
   logic signed [N-1:0]     multiplier;
   logic                    mul_start;
   logic                    mul_ready;
   logic signed [PW-1:0]    mul_product;

   // result write port
   logic                    out_valid;
   logic                    out_ready;
   logic        [RW-1:0]    out_row;
   logic        [JW-1:0]    out_col;
   logic        [ACC_W-1:0] out_data;

   modport master (
      output m_addr_row, m_addr_col, w_addr_row, w_addr_col,
      input  m_data, w_data,
      output multiplicand, multiplier, mul_start,
      input  mul_ready, mul_product,
      output out_valid, out_row, out_col, out_data,
      input  out_ready
   );

   modport slave (
      input  m_addr_row, m_addr_col, w_addr_row, w_addr_col,
      output m_data, w_data,
      input  multiplicand, multiplier, mul_start,
      output mul_ready, mul_product,
      input  out_valid, out_row, out_col, out_data,
      output out_ready
   );
endinterface

// File: rtl/matmul_sequencer.sv
// Sequences the shared multiplier through OUT = ReLU(M x W), row-major,
// one multiply per inner index k, accumulating signed products.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   go                start a job (sampled only in IDLE)
//   busy, done, error job status; error is sticky until reset or accepted go
//   bus (master)      operand memory reads, multiplier port, result port
module matmul_sequencer #(
   parameter int unsigned N       = 8,
   parameter int unsigned ROWS    = 402,
   parameter int unsigned COLUMNS = 26,
   parameter int unsigned W_COL   = 128,
   parameter int unsigned ACC_W   = 2*N+5,
   parameter int unsigned TIMEOUT = 2*N+4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               go,
   output logic               busy,
   output logic               done,
   output logic               error,
   matmul_sequencer_if.master bus
);
   localparam int unsigned RW = (ROWS > 1)    ? $clog2(ROWS)    : 1;
   localparam int unsigned KW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
   localparam int unsigned JW = (W_COL > 1)   ? $clog2(W_COL)   : 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DROP, WAIT, EMIT, DONE} state_t;

   state_t                  state, state_d;
   logic        [RW-1:0]    i, i_d;
   logic        [JW-1:0]    j, j_d;
   logic        [KW-1:0]    k, k_d;
   logic signed [ACC_W-1:0] acc, acc_d;
   logic        [TW-1:0]    tcnt, tcnt_d;
   logic                    busy_d, done_d, error_d, start_d, valid_d;
   logic        [RW-1:0]    ma_row, ma_row_d, o_row, o_row_d;
   logic        [KW-1:0]    ma_col, ma_col_d, wa_row, wa_row_d;
   logic        [JW-1:0]    wa_col, wa_col_d, o_col, o_col_d;
   logic signed [N-1:0]     mcand, mcand_d, mplier, mplier_d;
   logic        [ACC_W-1:0] o_data, o_data_d;
   logic                    mul_start_q, out_valid_q;

   assign bus.m_addr_row   = ma_row;
   assign bus.m_addr_col   = ma_col;
   assign bus.w_addr_row   = wa_row;
   assign bus.w_addr_col   = wa_col;
   assign bus.multiplicand = mcand;
   assign bus.multiplier   = mplier;
   assign bus.mul_start    = mul_start_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_row      = o_row;
   assign bus.out_col      = o_col;
   assign bus.out_data     = o_data;

   // Next-state, loop counters, accumulator and next values of every output register
   always_comb begin
      state_d  = state;
      i_d      = i;
      j_d      = j;
      k_d      = k;
      acc_d    = acc;
      tcnt_d   = tcnt;
      error_d  = error;
      mcand_d  = mcand;
      mplier_d = mplier;
      ma_row_d = ma_row;
      ma_col_d = ma_col;
      wa_row_d = wa_row;
      wa_col_d = wa_col;
      o_row_d  = o_row;
      o_col_d  = o_col;
      o_data_d = o_data;

      case (state)
         IDLE: if (go) begin
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            acc_d   = '0;
            error_d = 1'b0;
            state_d = FETCH;
         end
         FETCH: begin
            tcnt_d  = '0;
            state_d = LOAD;
         end
         // operands are only captured once the multiplier is free
         LOAD: begin
            if (bus.mul_ready) begin
               mcand_d  = bus.m_data;
               mplier_d = bus.w_data;
               state_d  = START;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               tcnt_d = tcnt + TW'(1);
            end
         end
         START: begin
            tcnt_d  = '0;
            state_d = DROP;
         end
         // a multiplier that did not drop Ready ignored our start
         DROP: begin
            if (bus.mul_ready) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               tcnt_d  = tcnt + TW'(1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.mul_ready) begin
               acc_d = acc + ACC_W'($signed(bus.mul_product));
               if (k == KW'(COLUMNS - 1)) begin
                  state_d = EMIT;
               end else begin
                  k_d     = k + KW'(1);
                  state_d = FETCH;
               end
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               tcnt_d = tcnt + TW'(1);
            end
         end
         EMIT: if (bus.out_ready) begin
            acc_d   = '0;
            k_d     = '0;
            state_d = FETCH;
            if (j == JW'(W_COL - 1)) begin
               j_d = '0;
               if (i == RW'(ROWS - 1)) begin
                  i_d     = '0;
                  state_d = DONE;
               end else begin
                  i_d = i + RW'(1);
               end
            end else begin
               j_d = j + JW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
      start_d = (state_d == START);
      valid_d = (state_d == EMIT);

      if (state_d == FETCH) begin
         ma_row_d = i_d;
         ma_col_d = k_d;
         wa_row_d = k_d;
         wa_col_d = j_d;
      end

      // result is frozen for the whole EMIT stay; negative sums clamp to zero
      if (state_d == EMIT) begin
         o_row_d  = i_d;
         o_col_d  = j_d;
         o_data_d = acc_d[ACC_W-1] ? '0 : acc_d;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         i           <= '0;
         j           <= '0;
         k           <= '0;
         acc         <= '0;
         tcnt        <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         mul_start_q <= 1'b0;
         out_valid_q <= 1'b0;
         mcand       <= '0;
         mplier      <= '0;
         ma_row      <= '0;
         ma_col      <= '0;
         wa_row      <= '0;
         wa_col      <= '0;
         o_row       <= '0;
         o_col       <= '0;
         o_data      <= '0;
      end else begin
         state       <= state_d;
         i           <= i_d;
         j           <= j_d;
         k           <= k_d;
         acc         <= acc_d;
         tcnt        <= tcnt_d;
         busy        <= busy_d;
         done        <= done_d;
         error       <= error_d;
         mul_start_q <= start_d;
         out_valid_q <= valid_d;
         mcand       <= mcand_d;
         mplier      <= mplier_d;
         ma_row      <= ma_row_d;
         ma_col      <= ma_col_d;
         wa_row      <= wa_row_d;
         wa_col      <= wa_col_d;
         o_row       <= o_row_d;
         o_col       <= o_col_d;
         o_data      <= o_data_d;
      end
   end
endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: memories and multiplier are modelled
// here, expected results come from a plain nested-loop ReLU(M x W).
module tb_matmul_sequencer;
   localparam int unsigned N       = 8;
   localparam int unsigned ROWS    = 3;
   localparam int unsigned COLUMNS = 26;
   localparam int unsigned W_COL   = 4;
   localparam int unsigned ACC_W   = 2*N+5;
   localparam int unsigned TIMEOUT = 2*N+4;
   localparam int unsigned PW      = 2*N;
   localparam int          JOB_BOUND = 20000;

   typedef struct {
      int     row;
      int     col;
      longint data;
   } exp_t;

   logic clk, rst, go, busy, done, error;
   matmul_sequencer_if #(.N(N), .ROWS(ROWS), .COLUMNS(COLUMNS), .W_COL(W_COL), .ACC_W(ACC_W)) bus ();

   matmul_sequencer #(
      .N(N), .ROWS(ROWS), .COLUMNS(COLUMNS), .W_COL(W_COL), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done), .error(error), .bus(bus)
   );

   logic signed [N-1:0] mem_m [ROWS][COLUMNS];
   logic signed [N-1:0] mem_w [COLUMNS][W_COL];
   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   done_cnt = 0;
   int   mode = 0;        // 0 normal multiplier, 1 Ready stuck high, 2 Ready never high
   int   lat_cnt = 0;
   int   ready_pct = 100;
   int   stall_en = 0;
   int   stall_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // synchronous-read operand memories
   always @(posedge clk) begin
      bus.m_data <= mem_m[int'(bus.m_addr_row)][int'(bus.m_addr_col)];
      bus.w_data <= mem_w[int'(bus.w_addr_row)][int'(bus.w_addr_col)];
   end

   // multiplier model: Ready drops after start, returns after a random latency
   always @(posedge clk) begin
      if (rst) begin
         bus.mul_ready <= (mode != 2);
         lat_cnt <= 0;
      end else if (mode == 1) begin
         bus.mul_ready <= 1'b1;
      end else if (mode == 2) begin
         bus.mul_ready <= 1'b0;
      end else if (bus.mul_start) begin
         bus.mul_ready   <= 1'b0;
         bus.mul_product <= PW'(int'(bus.multiplicand) * int'(bus.multiplier));
         lat_cnt         <= int'($urandom_range(1, 4));
      end else if (!bus.mul_ready) begin
         if (lat_cnt <= 1) bus.mul_ready <= 1'b1;
         else lat_cnt <= lat_cnt - 1;
      end
   end

   // output acceptor + monitor: compares every valid cycle against the queue head
   always @(negedge clk) begin
      if (bus.out_valid && stall_en != 0 && stall_cnt < 10 &&
          int'(bus.out_row) == 1 && int'(bus.out_col) == 2) begin
         bus.out_ready = 1'b0;
         stall_cnt++;
      end else if (stall_cnt == 10) begin
         bus.out_ready = 1'b1;
         stall_cnt = 11;
      end else begin
         bus.out_ready = (int'($urandom_range(0, 99)) < ready_pct);
      end

      if (!rst && bus.out_valid) begin
         check("out_expected_present", longint'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            check("out_row", longint'(bus.out_row), exp_q[0].row);
            check("out_col", longint'(bus.out_col), exp_q[0].col);
            check("out_data", longint'(bus.out_data), exp_q[0].data);
            if (bus.out_ready) void'(exp_q.pop_front());
         end
         check("no_mulstart_in_emit", longint'(bus.mul_start), 0);
      end
      if (!rst && done) done_cnt++;
   end

   function automatic void push_expected();
      for (int i = 0; i < int'(ROWS); i++) begin
         for (int j = 0; j < int'(W_COL); j++) begin
            longint s;
            exp_t   e;
            s = 0;
            for (int k = 0; k < int'(COLUMNS); k++)
               s += longint'(mem_m[i][k]) * longint'(mem_w[k][j]);
            e.row  = i;
            e.col  = j;
            e.data = (s < 0) ? 0 : s;
            exp_q.push_back(e);
         end
      end
   endfunction

   // fill: 0 random, 1 all -128, 2 M=-128 with W=127
   function automatic void fill(input int kind);
      for (int i = 0; i < int'(ROWS); i++)
         for (int k = 0; k < int'(COLUMNS); k++)
            mem_m[i][k] = (kind == 0) ? N'($urandom) : N'(-128);
      for (int k = 0; k < int'(COLUMNS); k++)
         for (int j = 0; j < int'(W_COL); j++)
            mem_w[k][j] = (kind == 0) ? N'($urandom) : (kind == 1) ? N'(-128) : N'(127);
   endfunction

   task automatic run_job(input bit noisy);
      int base, cyc;
      bit seen;
      push_expected();
      base = done_cnt;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      check("busy_after_go", longint'(busy), 1);
      check("error_cleared_by_go", longint'(error), 0);
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < JOB_BOUND) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            seen = 1'b1;
            check("queue_empty_at_done", longint'(exp_q.size()), 0);
            go = 1'b1;           // go during the DONE cycle must be ignored
         end else begin
            go = noisy && ($urandom_range(0, 15) == 0);
         end
      end
      check("job_done_seen", longint'(seen), 1);
      @(negedge clk);
      go = 1'b0;
      check("idle_after_done", longint'(busy), 0);
      repeat (3) @(negedge clk);
      check("still_idle", longint'(busy), 0);
      check("done_pulses", longint'(done_cnt - base), 1);
      check("no_error_in_job", longint'(error), 0);
      exp_q.delete();
   endtask

   initial begin
      int  cyc, base;
      bit  found;
      rst = 1'b1;
      go  = 1'b0;
      fill(0);
      repeat (3) @(negedge clk);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      check("rst_error", longint'(error), 0);
      check("rst_mul_start", longint'(bus.mul_start), 0);
      check("rst_out_valid", longint'(bus.out_valid), 0);
      check("rst_m_addr", longint'({bus.m_addr_row, bus.m_addr_col}), 0);
      check("rst_w_addr", longint'({bus.w_addr_row, bus.w_addr_col}), 0);
      check("rst_operands", longint'({bus.multiplicand, bus.multiplier}), 0);
      check("rst_out_coord", longint'({bus.out_row, bus.out_col}), 0);
      check("rst_out_data", longint'(bus.out_data), 0);
      rst = 1'b0;
      @(negedge clk);

      // small sums: (0,0) = 15-8 = 7, (0,1) = 3-20 clamps to 0
      fill(0);
      for (int k = 0; k < int'(COLUMNS); k++) begin
         mem_m[0][k] = '0;
         mem_w[k][0] = '0;
         mem_w[k][1] = '0;
      end
      mem_m[0][0] = N'(3);  mem_m[0][1] = N'(-4);
      mem_w[0][0] = N'(5);  mem_w[1][0] = N'(2);
      mem_w[0][1] = N'(1);  mem_w[1][1] = N'(5);
      run_job(1'b0);

      // operand extremes
      fill(1);
      run_job(1'b0);
      fill(2);
      run_job(1'b0);

      // random data, backpressure, a 10-cycle stall at (1,2), stray go pulses
      fill(0);
      ready_pct = 60;
      stall_en  = 1;
      stall_cnt = 0;
      run_job(1'b1);
      stall_en  = 0;
      ready_pct = 100;

      // reset while waiting on the multiplier at (0,3), k=10
      fill(0);
      push_expected();
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      found = 1'b0;
      cyc   = 0;
      while (!found && cyc < JOB_BOUND) begin
         @(negedge clk);
         cyc++;
         if (bus.mul_start && bus.m_addr_row == 0 && bus.m_addr_col == 10 && bus.w_addr_col == 3)
            found = 1'b1;
      end
      check("reached_0_3_k10", longint'(found), 1);
      @(negedge clk);            // DROP
      @(negedge clk);            // WAIT
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", longint'(busy), 0);
      check("midrst_mul_start", longint'(bus.mul_start), 0);
      check("midrst_out_valid", longint'(bus.out_valid), 0);
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      ready_pct = 80;
      run_job(1'b0);             // recomputes from (0,0)
      ready_pct = 100;

      // multiplier keeps Ready high after start
      mode = 1;
      base = done_cnt;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      found = 1'b0;
      cyc   = 0;
      while (!found && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (bus.mul_start) found = 1'b1;
      end
      check("stuck_start_seen", longint'(found), 1);
      @(negedge clk);
      @(negedge clk);
      check("stuck_error", longint'(error), 1);
      check("stuck_idle", longint'(busy), 0);
      repeat (5) @(negedge clk);
      check("stuck_no_done", longint'(done_cnt - base), 0);
      mode = 0;

      // multiplier never raises Ready
      mode = 2;
      base = done_cnt;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      cyc = 1;
      while (!error && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("timeout_error", longint'(error), 1);
      check("timeout_cycles_in_range", longint'(cyc >= int'(TIMEOUT) && cyc <= int'(TIMEOUT) + 2), 1);
      check("timeout_idle", longint'(busy), 0);
      repeat (5) @(negedge clk);
      check("timeout_no_done", longint'(done_cnt - base), 0);
      mode = 0;
      repeat (3) @(negedge clk);

      // a fresh go clears the sticky error and runs normally
      fill(0);
      ready_pct = 70;
      run_job(1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
